// File: rtl/dmi_host_bridge.sv
// Host-to-DMI bridge: one outstanding command, optional abort counter.
// Define DMI_HOST_BRIDGE_TIMEOUT_EN to enable the TIMEOUT_CYCLES abort.
module dmi_host_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_valid_i,
  output logic        host_req_ready_o,
  input  logic        host_wr_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_resp_valid_o,
  input  logic        host_resp_ready_i,
  output logic [31:0] host_rdata_o,
  output logic [1:0]  host_resp_code_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [1:0]  dmi_op_o,
  output logic [6:0]  dmi_addr_o,
  output logic [31:0] dmi_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_code_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        cmd_wr;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_code;
  logic        timeout;
  logic        busy;

  assign busy = (state == S_REQ) || (state == S_WAIT);

`ifdef DMI_HOST_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt;

  // Held at zero while idle, so it is already clear on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 16'd0;
    end else if (busy) begin
      cnt <= cnt + 16'd1;
    end else begin
      cnt <= 16'd0;
    end
  end

  assign timeout = busy && (cnt == TO_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = ^TO_LAST;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cmd_wr    <= 1'b0;
      cmd_addr  <= 7'd0;
      cmd_wdata <= 32'd0;
      rsp_data  <= 32'd0;
      rsp_code  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_req_valid_i) begin
            cmd_wr    <= host_wr_i;
            cmd_addr  <= host_addr_i;
            cmd_wdata <= host_wdata_i;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (timeout) begin
            rsp_data <= 32'd0;
            rsp_code <= 2'b01;
            state    <= S_RESP;
          end else if (dmi_req_ready_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the final cycle beats the abort.
          if (dmi_resp_valid_i) begin
            rsp_data <= dmi_resp_data_i;
            rsp_code <= (dmi_resp_code_i == 2'b01) ? 2'b10
                                                   : dmi_resp_code_i;
            state    <= S_RESP;
          end else if (timeout) begin
            rsp_data <= 32'd0;
            rsp_code <= 2'b01;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (host_resp_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host_req_ready_o  = (state == S_IDLE);
  assign host_resp_valid_o = (state == S_RESP);
  assign host_rdata_o      = rsp_data;
  assign host_resp_code_o  = rsp_code;
  assign dmi_req_valid_o   = (state == S_REQ);
  assign dmi_op_o          = (state != S_REQ) ? 2'b00
                           : (cmd_wr ? 2'b10 : 2'b01);
  assign dmi_addr_o        = cmd_addr;
  assign dmi_data_o        = cmd_wdata;
  // Only REQ refuses responses; elsewhere stray replies drain.
  assign dmi_resp_ready_o  = (state != S_REQ);

endmodule

// File: tb/tb_dmi_host_bridge.sv
// Directed + randomized bench for dmi_host_bridge; the bench plays
// both host and debug module and predicts each response from the rules.
module tb_dmi_host_bridge;

`ifdef DMI_HOST_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_wr;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_resp_valid;
  logic        host_resp_ready;
  logic [31:0] host_rdata;
  logic [1:0]  host_resp_code;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_data;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_code;

  int vectors = 0;
  int miscompares = 0;

  dmi_host_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .host_req_valid_i  (host_req_valid),
    .host_req_ready_o  (host_req_ready),
    .host_wr_i         (host_wr),
    .host_addr_i       (host_addr),
    .host_wdata_i      (host_wdata),
    .host_resp_valid_o (host_resp_valid),
    .host_resp_ready_i (host_resp_ready),
    .host_rdata_o      (host_rdata),
    .host_resp_code_o  (host_resp_code),
    .dmi_req_valid_o   (dmi_req_valid),
    .dmi_req_ready_i   (dmi_req_ready),
    .dmi_op_o          (dmi_op),
    .dmi_addr_o        (dmi_addr),
    .dmi_data_o        (dmi_data),
    .dmi_resp_valid_i  (dmi_resp_valid),
    .dmi_resp_ready_o  (dmi_resp_ready),
    .dmi_resp_data_i   (dmi_resp_data),
    .dmi_resp_code_i   (dmi_resp_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Host-visible status for a DMI status code.
  function automatic logic [1:0] host_code(input logic [1:0] c);
    return (c == 2'b01) ? 2'b10 : c;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".req_rdy"}, 32'(host_req_ready), 32'd1);
    chk({tag, ".rsp_vld"}, 32'(host_resp_valid), 32'd0);
    chk({tag, ".dreq_vld"}, 32'(dmi_req_valid), 32'd0);
    chk({tag, ".op"}, 32'(dmi_op), 32'd0);
    chk({tag, ".daddr"}, 32'(dmi_addr), 32'd0);
    chk({tag, ".ddata"}, dmi_data, 32'd0);
    chk({tag, ".drsp_rdy"}, 32'(dmi_resp_ready), 32'd1);
    chk({tag, ".rdata"}, host_rdata, 32'd0);
    chk({tag, ".code"}, 32'(host_resp_code), 32'd0);
  endtask

  task automatic accept(input logic wr, input logic [6:0] a,
                        input logic [31:0] d);
    chk("idle.req_rdy", 32'(host_req_ready), 32'd1);
    host_req_valid = 1'b1;
    host_wr = wr;
    host_addr = a;
    host_wdata = d;
    step();
    host_req_valid = 1'b0;
    host_wr = ~wr;
    host_addr = ~a;
    host_wdata = ~d;
  endtask

  // One full command with chosen handshake delays.
  task automatic txn(input logic wr, input logic [6:0] a,
                     input logic [31:0] d, input int req_dly,
                     input int rsp_dly, input logic [1:0] rc,
                     input logic [31:0] rd, input int hold);
    logic [1:0] op_exp;
    op_exp = wr ? 2'b10 : 2'b01;
    accept(wr, a, d);
    for (int i = 0; i <= req_dly; i++) begin
      chk("req.vld", 32'(dmi_req_valid), 32'd1);
      chk("req.op", 32'(dmi_op), 32'(op_exp));
      chk("req.addr", 32'(dmi_addr), 32'(a));
      chk("req.data", dmi_data, d);
      chk("req.rsp_vld", 32'(host_resp_valid), 32'd0);
      chk("req.req_rdy", 32'(host_req_ready), 32'd0);
      dmi_req_ready = (i == req_dly);
      step();
    end
    dmi_req_ready = 1'b0;
    for (int j = 0; j <= rsp_dly; j++) begin
      chk("wait.vld", 32'(dmi_req_valid), 32'd0);
      chk("wait.op", 32'(dmi_op), 32'd0);
      chk("wait.drsp_rdy", 32'(dmi_resp_ready), 32'd1);
      chk("wait.rsp_vld", 32'(host_resp_valid), 32'd0);
      dmi_resp_valid = (j == rsp_dly);
      dmi_resp_data = rd;
      dmi_resp_code = rc;
      step();
    end
    dmi_resp_valid = 1'b0;
    dmi_resp_data = $urandom;
    dmi_resp_code = 2'($urandom);
    for (int k = 0; k <= hold; k++) begin
      chk("resp.vld", 32'(host_resp_valid), 32'd1);
      chk("resp.rdata", host_rdata, rd);
      chk("resp.code", 32'(host_resp_code), 32'(host_code(rc)));
      chk("resp.req_rdy", 32'(host_req_ready), 32'd0);
      chk("resp.dreq_vld", 32'(dmi_req_valid), 32'd0);
      host_req_valid = 1'b1;
      host_resp_ready = (k == hold);
      step();
    end
    host_req_valid = 1'b0;
    host_resp_ready = 1'b0;
    chk("done.req_rdy", 32'(host_req_ready), 32'd1);
    chk("done.rsp_vld", 32'(host_resp_valid), 32'd0);
    chk("done.dreq_vld", 32'(dmi_req_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    host_req_valid = 1'b0;
    host_wr = 1'b0;
    host_addr = 7'd0;
    host_wdata = 32'd0;
    host_resp_ready = 1'b0;
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp_data = 32'd0;
    dmi_resp_code = 2'b00;
    step();
    step();
    chk_reset_outs("rst");
    rst = 1'b0;
    step();
    chk_reset_outs("post_rst");

    // Minimum latency read, then a stalled write.
    txn(1'b0, 7'h11, 32'h0, 0, 0, 2'b00, 32'h0000_0C82, 0);
    txn(1'b1, 7'h10, 32'h8000_0001, 5, 0, 2'b00, 32'h1234_5678, 0);
    // Busy status with a host that stalls the response.
    txn(1'b0, 7'h04, 32'h0, 0, 1, 2'b11, 32'hDEAD_BEEF, 4);
    // DMI code 01 reported to the host as failed.
    txn(1'b0, 7'h16, 32'h0, 1, 0, 2'b01, 32'h0000_00AA, 0);
    // Response arrives in the last cycle before an abort would fire.
    txn(1'b0, 7'h22, 32'h0, 3, 3, 2'b00, 32'h5555_AAAA, 0);

`ifdef DMI_HOST_BRIDGE_TIMEOUT_EN
    accept(1'b0, 7'h05, 32'h0);
    for (int i = 0; i < TO; i++) begin
      chk("to.pending", 32'(host_resp_valid), 32'd0);
      chk("to.dreq_vld", 32'(dmi_req_valid), 32'd1);
      step();
    end
    chk("to.rsp_vld", 32'(host_resp_valid), 32'd1);
    chk("to.code", 32'(host_resp_code), 32'd1);
    chk("to.rdata", host_rdata, 32'd0);
    chk("to.dreq_vld_drop", 32'(dmi_req_valid), 32'd0);
    chk("to.op", 32'(dmi_op), 32'd0);
    host_resp_ready = 1'b1;
    step();
    host_resp_ready = 1'b0;
    chk("to.late_rdy", 32'(dmi_resp_ready), 32'd1);
    dmi_resp_valid = 1'b1;
    dmi_resp_data = 32'hBAD0_BAD0;
    dmi_resp_code = 2'b00;
    step();
    dmi_resp_valid = 1'b0;
    txn(1'b0, 7'h05, 32'h0, 0, 0, 2'b00, 32'h0000_0777, 0);
`else
    // Without the abort the bridge waits as long as the DM needs.
    txn(1'b0, 7'h30, 32'h0, 40, 40, 2'b00, 32'h0BAD_F00D, 0);
`endif

    // Reset while waiting for the DM, then drain the late reply.
    accept(1'b0, 7'h11, 32'h0);
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outs("mid_rst");
    dmi_resp_valid = 1'b1;
    dmi_resp_data = 32'hCAFE_0001;
    step();
    dmi_resp_valid = 1'b0;
    chk("mid_rst.no_rsp", 32'(host_resp_valid), 32'd0);
    txn(1'b0, 7'h11, 32'h0, 0, 0, 2'b00, 32'h0000_0C82, 0);

    // Randomized commands within the abort window.
    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom), 7'($urandom), $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          2'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmi_host_bridge.md
DMI_HOST_BRIDGE -- requirements
Module: dmi_host_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles in REQ+WAIT before abort; legal range 2..65535.
REQ-002 clk_i  in  1  sole clock; all logic rising-edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 host_req_valid_i  in  1  host command valid.
REQ-005 host_req_ready_o  out  1  bridge accepts command.
REQ-006 host_wr_i  in  1  1=DMI write, 0=DMI read.
REQ-007 host_addr_i  in  7  DMI register address.
REQ-008 host_wdata_i  in  32  write data.
REQ-009 host_resp_valid_o  out  1  response valid.
REQ-010 host_resp_ready_i  in  1  host accepts response.
REQ-011 host_rdata_o  out  32  response data.
REQ-012 host_resp_code_o  out  2  00 ok, 01 timeout, 10 failed, 11 busy.
REQ-013 dmi_req_valid_o  out  1  DMI request valid to debug module.
REQ-014 dmi_req_ready_i  in  1  debug module accepts request.
REQ-015 dmi_op_o  out  2  01 read, 10 write; 00 (NOP) when dmi_req_valid_o=0.
REQ-016 dmi_addr_o  out  7  latched address.
REQ-017 dmi_data_o  out  32  latched write data.
REQ-018 dmi_resp_valid_i  in  1  DMI response valid.
REQ-019 dmi_resp_ready_o  out  1  bridge accepts DMI response.
REQ-020 dmi_resp_data_i  in  32  DMI response data.
REQ-021 dmi_resp_code_i  in  2  DMI response status (00/10/11).

Function
REQ-022 FSM states IDLE, REQ, WAIT, RESP; exactly one command outstanding.
REQ-023 IDLE: host_req_ready_o=1; on host_req_valid_i latch wr/addr/wdata, clear counter, next REQ.
REQ-024 REQ: dmi_req_valid_o=1, fields stable from latch; on dmi_req_ready_i next WAIT.
REQ-025 WAIT: on dmi_resp_valid_i latch data and code into response regs, next RESP.
REQ-026 RESP: host_resp_valid_o=1, rdata/code stable; on host_resp_ready_i next IDLE.
REQ-027 dmi_resp_ready_o=1 in WAIT, IDLE and RESP; responses arriving outside WAIT discarded (drains late replies).
REQ-028 Minimum latency accept->host_resp_valid_o: 3 cycles with same-cycle DMI ready/valid.
REQ-029 Write responses return dmi_resp_data_i unchanged; host ignores data for writes.
REQ-030 host_resp_code_o passes dmi_resp_code_i; code 01 from DMI is mapped to 10.
REQ-031 No combinational path from any input to any output except none; all outputs decode FSM state or registers.

Reset
REQ-032 rst_i high: state IDLE, counter 0, response regs 0, latched cmd 0, effective next edge.
REQ-033 Outputs during/after reset: host_req_ready_o=1, host_resp_valid_o=0, dmi_req_valid_o=0, dmi_op_o=00, dmi_addr_o=0, dmi_data_o=0, dmi_resp_ready_o=1, host_rdata_o=0, host_resp_code_o=00.
REQ-034 Reset mid-transaction abandons command without host response; late DMI response drained per REQ-027.

Configuration
REQ-035 Macro DMI_HOST_BRIDGE_TIMEOUT_EN defined: 16-bit counter increments each cycle in REQ and WAIT; on reaching TIMEOUT_CYCLES-1 without completion that cycle, go RESP with rdata=0, code=01, dmi_req_valid_o dropped.
REQ-036 Timeout and completion in same cycle: completion wins.
REQ-037 Macro undefined: no counter, bridge waits indefinitely; code 01 never produced.

Verification
REQ-038 Read addr 0x11, DM ready/valid immediate, data 0x0000_0C82 code 00 -> host rdata 0x0000_0C82, code 00, 3 cycles after accept.
REQ-039 Write addr 0x10 data 0x8000_0001, dmi_req_ready_i held low 5 cycles -> dmi_req_valid_o held 6 cycles, op 10, addr/data stable, then code 00.
REQ-040 DMI returns code 11 on read -> host code 11; host_resp_ready_i low 4 cycles -> response held stable, no new command accepted.
REQ-041 TIMEOUT_EN, TIMEOUT_CYCLES=8, no DMI response -> host code 01 rdata 0 after 8 cycles in REQ+WAIT; late response discarded, next read returns its own data.
REQ-042 rst_i asserted in WAIT -> next cycle all outputs per REQ-033; following read completes normally.
